l2_tcdm_xbar: RTL and testbench
===============================

Name: l2_tcdm_xbar

Overview:
- Parametrised N-master to N-bank word-interleaved crossbar for the SoC L2 scratchpad.
- Replaces the fixed 4 AXI-bridge ports plus 2 uDMA channel wiring into the L2 banks with one generic block.
- Masters and bank count are parameters. Each bank has round-robin arbitration and single-cycle response routing.
- Sits between the AXI-to-TCDM bridge / uDMA TCDM channels and the L2 SRAM bank macros, in the SoC clock domain.

Parameters:
- N_MASTERS, 6, number of TCDM master ports (4 AXI bridge + 2 uDMA); range 1..16.
- N_BANKS, 8, number of L2 banks; must be a power of 2, range 2..32.
- ADDR_WIDTH, 32, master byte-address width.
- DATA_WIDTH, 32, word width; fixed at 32 for L2.
- BANK_ADDR_WIDTH, 15, word-address width of one bank.

Ports:
- clk_i  in  1  SoC clock.
- rst_i  in  1  synchronous reset, active-high.
- m_req_i  in  N_MASTERS  per-master request.
- m_gnt_o  out  N_MASTERS  per-master grant; combinational from requests and arbiter state.
- m_add_i  in  N_MASTERS*ADDR_WIDTH  byte address.
- m_we_i  in  N_MASTERS  1 = write, 0 = read.
- m_be_i  in  N_MASTERS*4  byte enables.
- m_wdata_i  in  N_MASTERS*DATA_WIDTH  write data.
- m_rvalid_o  out  N_MASTERS  response valid.
- m_rdata_o  out  N_MASTERS*DATA_WIDTH  read data.
- b_req_o  out  N_BANKS  bank chip-select.
- b_we_o  out  N_BANKS  bank write enable.
- b_addr_o  out  N_BANKS*BANK_ADDR_WIDTH  bank word address.
- b_be_o  out  N_BANKS*4  bank byte enables.
- b_wdata_o  out  N_BANKS*DATA_WIDTH  bank write data.
- b_rdata_i  in  N_BANKS*DATA_WIDTH  bank read data; valid 1 cycle after b_req_o.

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high (clk_i, rst_i).
- While rst_i=1:
  - m_gnt_o=0 and b_req_o=0.
  - All round-robin pointers are cleared to 0.
  - m_rvalid_o=0 and m_rdata_o=0 on the cycle after the reset edge.
- Address decode, with LB=log2(N_BANKS):
  - bank = m_add[2+:LB].
  - row = m_add[2+LB+:BANK_ADDR_WIDTH].
  - Bits [1:0] and bits above the row are ignored, so addresses wrap modulo the L2 size.
- Arbitration, per bank:
  - Candidates are masters with m_req_i=1 whose decoded bank matches.
  - The winner is the first candidate at index >= rr_q[bank], searching upward with wrap-around.
  - The winner gets m_gnt_o=1 in the same cycle, and its we/be/wdata/row drive that bank's outputs.
  - On the clock edge: rr_q[bank] <= (winner+1) mod N_MASTERS. With no candidate the pointer holds and b_req_o=0.
- Bank-side outputs when b_req_o=0: b_we_o, b_addr_o, b_be_o and b_wdata_o are 0.
- Master protocol:
  - Once raised, a request keeps req/add/we/be/wdata stable until granted.
  - A master issues at most one request per cycle, so it wins at most one bank per cycle.
- Response path:
  - Registered winner index and valid per bank: resp_idx_q[bank], resp_v_q[bank].
  - One cycle after a grant, m_rvalid_o[winner]=1 for both reads and writes.
  - For reads, m_rdata_o[winner] = b_rdata_i[bank]. For writes, rdata is 0.
  - Latency is fixed: grant to rvalid is 1 cycle.
- Back-to-back grants to the same master are allowed every cycle, and responses arrive in order.
- Fairness: under continuous contention on one bank, every requester is granted within N_MASTERS cycles.
- Simultaneous events:
  - Masters targeting different banks are all granted in the same cycle, with no cross-bank coupling.
  - A request, grant and a response for a previous grant on the same master in one cycle is legal.
- Reset asserted mid-transaction: pending responses are dropped, with no rvalid on the cycle after the reset edge. Masters must reissue.

Optional Feature:
- Macro: L2_TCDM_XBAR_PRIO_EN.
- When defined:
  - Adds input port m_prio_i (N_MASTERS), 1 = high priority.
  - Per bank, if any candidate has prio=1, only high-priority candidates are eligible; otherwise all candidates are eligible.
  - Round-robin and pointer update apply within the eligible set.
  - Starvation guard: a 4-bit counter per bank counts consecutive cycles in which a low-priority candidate lost.
  - When the counter reaches 15, the next grant goes to the low-priority round-robin winner, and the counter clears.
  - The counter clears on any low-priority grant or when no low-priority candidate is present, and resets to 0.
- When undefined: no m_prio_i port, pure round-robin as above.

Test Plan:
- Reset held 3 cycles with all m_req_i=1 -> m_gnt_o=0 and b_req_o=0 throughout; first cycle after release: master 0 granted, rvalid 0.
- Master 1 writes 0xDEADBEEF, be=0xF, to 0x0000_0104 (bank 1, row 8); next cycle reads it -> write grant same cycle, b_addr_o[1]=8, rvalid 1 cycle later; read returns 0xDEADBEEF 1 cycle after its grant.
- Masters 0, 2 and 5 continuously request bank 3 (address 0x0C) -> grants in order 0, 2, 5, 0, 2, 5; each rvalid 1 cycle after its grant.
- Six masters target addresses 0x00, 0x04, ..., 0x14 (banks 0-5) in the same cycle -> all six granted in the same cycle, all six rvalid next cycle, rdata routed correctly.
- rst_i pulsed 1 cycle immediately after master 3's read grant -> no m_rvalid_o[3] on the cycle after the reset edge; rr pointers return to 0.
- With L2_TCDM_XBAR_PRIO_EN: master 4 prio=1 and master 1 prio=0 both hold on bank 2 -> master 4 wins 15 cycles, master 1 wins the 16th, pattern repeats.

Source files
------------

// File: rtl/l2_tcdm_xbar.sv
// l2_tcdm_xbar: N-master to N-bank word-interleaved L2 crossbar, per-bank round-robin.
// Define L2_TCDM_XBAR_PRIO_EN to add m_prio_i priority classes with a starvation guard.
module l2_tcdm_xbar #(
    parameter int N_MASTERS       = 6,
    parameter int N_BANKS         = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BANK_ADDR_WIDTH = 15
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [N_MASTERS-1:0]                 m_req_i,
`ifdef L2_TCDM_XBAR_PRIO_EN
    input  logic [N_MASTERS-1:0]                 m_prio_i,
`endif
    output logic [N_MASTERS-1:0]                 m_gnt_o,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]      m_add_i,
    input  logic [N_MASTERS-1:0]                 m_we_i,
    input  logic [N_MASTERS*4-1:0]               m_be_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]      m_wdata_i,
    output logic [N_MASTERS-1:0]                 m_rvalid_o,
    output logic [N_MASTERS*DATA_WIDTH-1:0]      m_rdata_o,
    output logic [N_BANKS-1:0]                   b_req_o,
    output logic [N_BANKS-1:0]                   b_we_o,
    output logic [N_BANKS*BANK_ADDR_WIDTH-1:0]   b_addr_o,
    output logic [N_BANKS*4-1:0]                 b_be_o,
    output logic [N_BANKS*DATA_WIDTH-1:0]        b_wdata_o,
    input  logic [N_BANKS*DATA_WIDTH-1:0]        b_rdata_i
);

    localparam int LB  = $clog2(N_BANKS);
    localparam int MW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int DW  = DATA_WIDTH;
    localparam int BAW = BANK_ADDR_WIDTH;

    logic [LB-1:0]        w_mbank    [N_MASTERS];
    logic [BAW-1:0]       w_mrow     [N_MASTERS];
    logic [N_MASTERS-1:0] w_cand     [N_BANKS];
    logic [N_BANKS-1:0]   w_hit;
    logic [MW-1:0]        w_win      [N_BANKS];
    logic [MW-1:0]        r_rr       [N_BANKS];
    logic [N_BANKS-1:0]   r_resp_v;
    logic [N_BANKS-1:0]   r_resp_we;
    logic [MW-1:0]        r_resp_idx [N_BANKS];
    logic                 w_unused_add;

`ifdef L2_TCDM_XBAR_PRIO_EN
    logic [N_BANKS-1:0]   w_lp_any;
    logic [N_BANKS-1:0]   w_win_lp;
    logic [3:0]           r_starve   [N_BANKS];
`endif

    // Offset bits and bits above the row are dropped so addresses wrap.
    assign w_unused_add = ^m_add_i;

    // Returns {found, index}: first set bit of c at or above ptr, wrapping.
    function automatic logic [MW:0] rr_pick(
        input logic [N_MASTERS-1:0] c,
        input logic [MW-1:0]        ptr
    );
        logic [MW:0] r;
        int          j;
        r = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_MASTERS) j = j - N_MASTERS;
            if (c[MW'(j)]) r = {1'b1, MW'(j)};
        end
        return r;
    endfunction

    always_comb begin
        for (int m = 0; m < N_MASTERS; m++) begin
            w_mbank[m] = m_add_i[m*ADDR_WIDTH+2 +: LB];
            w_mrow[m]  = m_add_i[m*ADDR_WIDTH+2+LB +: BAW];
        end
        for (int b = 0; b < N_BANKS; b++) begin
            w_cand[b] = '0;
            for (int m = 0; m < N_MASTERS; m++)
                w_cand[b][m] = m_req_i[m] && (w_mbank[m] == LB'(b));
        end
    end

    always_comb begin
        logic [MW:0]          w_pick;
`ifdef L2_TCDM_XBAR_PRIO_EN
        logic [MW:0]          w_lpick;
        logic [N_MASTERS-1:0] w_hp;
        logic [N_MASTERS-1:0] w_lp;
`endif
        for (int b = 0; b < N_BANKS; b++) begin
`ifdef L2_TCDM_XBAR_PRIO_EN
            w_hp    = w_cand[b] & m_prio_i;
            w_lp    = w_cand[b] & ~m_prio_i;
            w_pick  = rr_pick((|w_hp) ? w_hp : w_cand[b], r_rr[b]);
            w_lpick = rr_pick(w_lp, r_rr[b]);
            // A starved low-priority requester overrides the high class once.
            if ((r_starve[b] == 4'hF) && w_lpick[MW])
                w_pick = w_lpick;
            w_lp_any[b] = |w_lp;
            w_win_lp[b] = w_pick[MW] && !m_prio_i[w_pick[MW-1:0]];
`else
            w_pick = rr_pick(w_cand[b], r_rr[b]);
`endif
            w_hit[b] = w_pick[MW] && !rst_i;
            w_win[b] = w_pick[MW-1:0];
        end
    end

    always_comb begin
        m_gnt_o = '0;
        for (int b = 0; b < N_BANKS; b++)
            for (int m = 0; m < N_MASTERS; m++)
                if (w_hit[b] && (w_win[b] == MW'(m)))
                    m_gnt_o[m] = 1'b1;
    end

    always_comb begin
        b_req_o   = w_hit;
        b_we_o    = '0;
        b_addr_o  = '0;
        b_be_o    = '0;
        b_wdata_o = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            if (w_hit[b]) begin
                b_we_o[b]               = m_we_i[w_win[b]];
                b_addr_o[b*BAW +: BAW]  = w_mrow[w_win[b]];
                b_be_o[b*4 +: 4]        = m_be_i[w_win[b]*4 +: 4];
                b_wdata_o[b*DW +: DW]   = m_wdata_i[w_win[b]*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_v  <= '0;
            r_resp_we <= '0;
            for (int b = 0; b < N_BANKS; b++) begin
                r_rr[b]       <= '0;
                r_resp_idx[b] <= '0;
            end
        end else begin
            r_resp_v <= w_hit;
            for (int b = 0; b < N_BANKS; b++) begin
                if (w_hit[b]) begin
                    r_rr[b]       <= (w_win[b] == MW'(N_MASTERS - 1)) ?
                                     '0 : w_win[b] + 1'b1;
                    r_resp_idx[b] <= w_win[b];
                    r_resp_we[b]  <= m_we_i[w_win[b]];
                end
            end
        end
    end

`ifdef L2_TCDM_XBAR_PRIO_EN
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < N_BANKS; b++) begin
            if (rst_i || !w_lp_any[b] || w_win_lp[b])
                r_starve[b] <= '0;
            else if (r_starve[b] != 4'hF)
                r_starve[b] <= r_starve[b] + 4'd1;
        end
    end
`endif

    // Bank data is valid one cycle after the select, matching the registered winner.
    always_comb begin
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            if (r_resp_v[b] && !rst_i) begin
                m_rvalid_o[r_resp_idx[b]] = 1'b1;
                if (!r_resp_we[b])
                    m_rdata_o[r_resp_idx[b]*DW +: DW] = b_rdata_i[b*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_l2_tcdm_xbar.sv
// tb_l2_tcdm_xbar: directed checks of grants, bank routing and responses of l2_tcdm_xbar.
// Build with L2_TCDM_XBAR_PRIO_EN to also exercise the priority starvation guard.
module tb_l2_tcdm_xbar;

    localparam int NM = 6;
    localparam int NB = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NM-1:0]   req;
    logic [NM-1:0]   prio;
    logic [NM-1:0]   gnt;
    logic [NM*32-1:0] add;
    logic [NM-1:0]   we;
    logic [NM*4-1:0] be;
    logic [NM*32-1:0] wdata;
    logic [NM-1:0]   rvalid;
    logic [NM*32-1:0] rdata;
    logic [NB-1:0]   b_req;
    logic [NB-1:0]   b_we;
    logic [NB*15-1:0] b_addr;
    logic [NB*4-1:0] b_be;
    logic [NB*32-1:0] b_wdata;
    logic [NB*32-1:0] b_rdata = '0;

    logic [31:0] mem [NB][64];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    l2_tcdm_xbar dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_req_i    (req),
`ifdef L2_TCDM_XBAR_PRIO_EN
        .m_prio_i   (prio),
`endif
        .m_gnt_o    (gnt),
        .m_add_i    (add),
        .m_we_i     (we),
        .m_be_i     (be),
        .m_wdata_i  (wdata),
        .m_rvalid_o (rvalid),
        .m_rdata_o  (rdata),
        .b_req_o    (b_req),
        .b_we_o     (b_we),
        .b_addr_o   (b_addr),
        .b_be_o     (b_be),
        .b_wdata_o  (b_wdata),
        .b_rdata_i  (b_rdata)
    );

    // Bank SRAM model: read-before-write, data one cycle after select.
    always @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < 64; r++)
                    mem[b][r] <= '0;
            b_rdata <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (b_req[b]) begin
                    b_rdata[b*32 +: 32] <= mem[b][b_addr[b*15 +: 6]];
                    if (b_we[b])
                        for (int k = 0; k < 4; k++)
                            if (b_be[b*4+k])
                                mem[b][b_addr[b*15 +: 6]][k*8 +: 8]
                                    <= b_wdata[b*32+k*8 +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int m, input logic r, input logic [31:0] a,
                         input logic w, input logic [31:0] d);
        req[m]          = r;
        add[m*32 +: 32] = a;
        we[m]           = w;
        be[m*4 +: 4]    = 4'hF;
        wdata[m*32 +: 32] = d;
    endtask

    task automatic idle();
        req = '0;
        we  = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seq [6];
        seq = '{0, 2, 5, 0, 2, 5};
        rst   = 1'b1;
        prio  = '0;
        req   = '0;
        add   = '0;
        we    = '0;
        be    = '0;
        wdata = '0;
        for (int m = 0; m < NM; m++) drive(m, 1'b1, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_breq", 32'(b_req), 32'h0);
            chk("rst_rvalid", 32'(rvalid), 32'h0);
            next();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rel_gnt", 32'(gnt), 32'h01);
        chk("rel_breq", 32'(b_req), 32'h01);
        chk("rel_rvalid", 32'(rvalid), 32'h0);
        next();
        idle();
        @(negedge clk);
        chk("rel_rsp", 32'(rvalid), 32'h01);
        chk("idle_breq", 32'(b_req), 32'h0);
        chk("idle_addr0", 32'(b_addr[0 +: 15]), 32'h0);
        next();

        // write then read back through bank 1, row 8
        drive(1, 1'b1, 32'h0000_0104, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_gnt", 32'(gnt), 32'h02);
        chk("wr_breq", 32'(b_req), 32'h02);
        chk("wr_addr", 32'(b_addr[15 +: 15]), 32'd8);
        chk("wr_we", 32'(b_we), 32'h02);
        chk("wr_be", 32'(b_be[4 +: 4]), 32'hF);
        chk("wr_data", b_wdata[32 +: 32], 32'hDEAD_BEEF);
        chk("wr_rvalid", 32'(rvalid), 32'h0);
        next();
        drive(1, 1'b1, 32'h0000_0104, 1'b0, 32'h0);
        @(negedge clk);
        chk("rd_gnt", 32'(gnt), 32'h02);
        chk("rd_we", 32'(b_we), 32'h0);
        chk("wr_rsp_v", 32'(rvalid), 32'h02);
        chk("wr_rsp_d", rdata[32 +: 32], 32'h0);
        next();
        drive(1, 1'b1, 32'h0000_0104, 1'b1, 32'h1234_5678);
        @(negedge clk);
        chk("rd_rsp_v", 32'(rvalid), 32'h02);
        chk("rd_rsp_d", rdata[32 +: 32], 32'hDEAD_BEEF);
        next();
        idle();
        @(negedge clk);
        chk("wr2_rsp_v", 32'(rvalid), 32'h02);
        chk("wr2_rsp_zero", rdata[32 +: 32], 32'h0);
        chk("idle_gnt", 32'(gnt), 32'h0);
        next();

        // contention on bank 3
        drive(0, 1'b1, 32'h0C, 1'b0, 32'h0);
        drive(2, 1'b1, 32'h0C, 1'b0, 32'h0);
        drive(5, 1'b1, 32'h0C, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(gnt), 32'(1) << seq[i]);
            chk("rr_breq", 32'(b_req), 32'h08);
            chk("rr_rvalid", 32'(rvalid),
                (i == 0) ? 32'h0 : 32'(1) << seq[i-1]);
            next();
        end
        idle();
        @(negedge clk);
        chk("rr_last_rsp", 32'(rvalid), 32'h20);
        next();

        // all six masters on banks 0..5 at once
        for (int m = 0; m < NM; m++)
            drive(m, 1'b1, 32'(m * 4), 1'b1, 32'hC0DE_0000 | 32'(m));
        @(negedge clk);
        chk("par_wgnt", 32'(gnt), 32'h3F);
        chk("par_wbreq", 32'(b_req), 32'h3F);
        next();
        for (int m = 0; m < NM; m++)
            drive(m, 1'b1, 32'(m * 4), 1'b0, 32'h0);
        @(negedge clk);
        chk("par_rgnt", 32'(gnt), 32'h3F);
        chk("par_wrsp", 32'(rvalid), 32'h3F);
        next();
        idle();
        @(negedge clk);
        chk("par_rrsp", 32'(rvalid), 32'h3F);
        for (int m = 0; m < NM; m++)
            chk($sformatf("par_rdata%0d", m), rdata[m*32 +: 32],
                32'hC0DE_0000 | 32'(m));
        next();

        // reset right after master 3's read grant on bank 0
        drive(3, 1'b1, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'h08);
        next();
        idle();
        rst = 1'b1;
        next();
        rst = 1'b0;
        drive(0, 1'b1, 32'h0, 1'b0, 32'h0);
        drive(5, 1'b1, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("mid_drop", 32'(rvalid), 32'h0);
        chk("mid_rr0", 32'(gnt), 32'h01);
        next();
        drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("mid_rr1", 32'(gnt), 32'h20);
        chk("mid_rsp", 32'(rvalid), 32'h01);
        next();
        idle();
        next();

`ifdef L2_TCDM_XBAR_PRIO_EN
        prio[4] = 1'b1;
        drive(4, 1'b1, 32'h08, 1'b0, 32'h0);
        drive(1, 1'b1, 32'h08, 1'b0, 32'h0);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            chk($sformatf("prio_gnt%0d", i), 32'(gnt),
                (i % 16 == 0) ? 32'h02 : 32'h10);
            next();
        end
        idle();
        prio = '0;
        next();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
